// File: rtl/register_file.sv
// 32 x 32-bit architectural register file with per-register rename status (busy + ROB tag).
// Optional same-cycle commit-to-read forwarding is enabled by defining REGFILE_COMMIT_BYPASS_EN.
module register_file #(
  parameter int ROB_BITS = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_en,
  input  logic [4:0]          issue_rd,
  input  logic [ROB_BITS-1:0] issue_tag,
  input  logic                commit_en,
  input  logic [4:0]          commit_rd,
  input  logic [ROB_BITS-1:0] commit_tag,
  input  logic [31:0]         commit_value,
  input  logic                flush,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  output logic [31:0]         rs1_value,
  output logic [31:0]         rs2_value,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ROB_BITS-1:0] rs1_tag,
  output logic [ROB_BITS-1:0] rs2_tag
);

  logic [31:0]         r_value [32];
  logic                r_busy  [32];
  logic [ROB_BITS-1:0] r_tag   [32];

  logic w_issue_we;
  logic w_commit_we;
  logic w_commit_clr;

  assign w_issue_we   = rdy_in && issue_en && !flush && (issue_rd != 5'd0);
  assign w_commit_we  = rdy_in && commit_en && (commit_rd != 5'd0);
  assign w_commit_clr = w_commit_we && r_busy[commit_rd] && (r_tag[commit_rd] == commit_tag);

  // Statement order matters: flush/commit clear busy first, a same-cycle issue then overrides.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_value[i] <= '0;
        r_busy[i]  <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < 32; i++) begin
          r_busy[i] <= 1'b0;
        end
      end
      if (w_commit_we) begin
        r_value[commit_rd] <= commit_value;
      end
      if (w_commit_clr) begin
        r_busy[commit_rd] <= 1'b0;
      end
      if (w_issue_we) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_tag;
      end
    end
  end

  always_comb begin
    rs1_value = '0;
    rs1_busy  = 1'b0;
    rs1_tag   = '0;
    if (rs1_id != 5'd0) begin
      rs1_value = r_value[rs1_id];
      rs1_busy  = r_busy[rs1_id];
      rs1_tag   = r_tag[rs1_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (w_commit_we && (commit_rd == rs1_id)) begin
        rs1_value = commit_value;
        rs1_busy  = !flush && r_busy[rs1_id] && (r_tag[rs1_id] != commit_tag);
      end
`endif
    end
  end

  always_comb begin
    rs2_value = '0;
    rs2_busy  = 1'b0;
    rs2_tag   = '0;
    if (rs2_id != 5'd0) begin
      rs2_value = r_value[rs2_id];
      rs2_busy  = r_busy[rs2_id];
      rs2_tag   = r_tag[rs2_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (w_commit_we && (commit_rd == rs2_id)) begin
        rs2_value = commit_value;
        rs2_busy  = !flush && r_busy[rs2_id] && (r_tag[rs2_id] != commit_tag);
      end
`endif
    end
  end

endmodule

// File: doc/register_file.md
# register_file

- 32 × 32-bit architectural register file with per-register rename status.
- Sits directly downstream of the reorder buffer's commit port and beside the issue stage.
- Issue marks a destination register busy with the ROB tag that will produce it.
- Commit writes the retired value and clears busy only if the tag still matches. Flush clears all rename status.
- Two combinational read ports give operand value, busy flag and producer tag to the issue logic.

## Interface
- `ROB_BITS`, default 4: width of ROB tags.
- `clk_in`  input  1  system clock; all state updates on the rising edge.
- `rst_in`  input  1  reset, asynchronous, active-low.
- `rdy_in`  input  1  when low, no state changes; read ports stay live.
- `issue_en`  input  1  rename request this cycle.
- `issue_rd`  input  5  destination register of the issuing instruction.
- `issue_tag`  input  ROB_BITS  ROB entry allocated to it.
- `commit_en`  input  1  ROB retires a register-writing entry.
- `commit_rd`  input  5  destination register of the retiring entry.
- `commit_tag`  input  ROB_BITS  ROB entry being retired.
- `commit_value`  input  32  result being retired.
- `flush`  input  1  misprediction recovery; discard all rename status.
- `rs1_id`, `rs2_id`  input  5 each  source register selects.
- `rs1_value`, `rs2_value`  output  32 each  operand value.
- `rs1_busy`, `rs2_busy`  output  1 each  operand still pending in the ROB.
- `rs1_tag`, `rs2_tag`  output  ROB_BITS each  producing ROB entry; meaningful only when busy.

## Operation
- State per register: `value[31:0]`, `busy`, `tag[ROB_BITS-1:0]`.
- Register x0:
  - always reads value 0, busy 0, tag 0.
  - Issue and commit targeting x0 are ignored.
- Reset (`rst_in`=0, asynchronous):
  - all values, busy bits and tags go to 0.
  - Read outputs therefore present 0/0/0 for every id.
  - Reset asserted mid-operation discards pending renames immediately.
- Issue (`issue_en`, `rdy_in`, `!flush`, `issue_rd`≠0):
  - `busy[issue_rd]`<=1 and `tag[issue_rd]`<=`issue_tag`.
  - Value is unchanged.
- Commit (`commit_en`, `rdy_in`, `commit_rd`≠0):
  - `value[commit_rd]`<=`commit_value` unconditionally.
  - `busy[commit_rd]`<=0 only when busy=1 and `tag[commit_rd]`==`commit_tag`.
  - A tag mismatch means a younger producer exists; busy and tag are kept.
- Issue and commit to the same rd in the same cycle:
  - the value is written by commit.
  - busy=1 and tag=`issue_tag` come from issue; issue wins.
- Flush (`flush`, `rdy_in`):
  - every busy bit is cleared and tags are left stale.
  - Issue in the same cycle is ignored.
  - Commit in the same cycle still writes its value, since the retiring entry is older than the mispredict.
- `rdy_in`=0: every write is suppressed, including flush.
- Reads return state from before the current cycle's issue. The issuing instruction sees its sources before its own rename.

## Timing
- Read ports are purely combinational from `rs*_id` and registered state, with zero cycles of latency.
- Issue, commit and flush take effect at the next rising edge and are visible on the read ports the following cycle.
- With bypass enabled, commit is also visible in the same cycle (see Configuration).
- Read outputs have no registered reset value; they track the state, which resets to zero.
- There is no handshake. The ROB guarantees at most one commit per cycle, and the issue stage guarantees at most one issue per cycle.

## Configuration
- Macro: `REGFILE_COMMIT_BYPASS_EN`.
- Defined: when `commit_en` and `commit_rd`==`rs*_id`≠0 (also gated by `rdy_in`), the read port returns the following in the same cycle:
  - `rs*_value`=`commit_value`
  - `rs*_busy`=`busy` && (`tag`≠`commit_tag`)
  - `rs*_busy`=0 when `flush` is also asserted.
  - This closes the one-cycle commit-to-issue hazard.
- Not defined: read ports reflect registered state only. The issue stage must obtain an operand from the ROB when its tag matches the committing entry.

## Test plan
- Reset:
  - Stimulus: assert `rst_in`=0 with random state loaded; release.
  - Required: all 32 ids read value 0, busy 0, tag 0. Issue/commit to x0 with value 0xDEADBEEF leaves x0 reading 0/0/0.
- Rename then commit:
  - Stimulus: issue rd=5 with tag 3; next cycle, commit rd=5 with tag 3 and value 0x1234.
  - Required: rs1_id=5 reads busy=1, tag=3, value 0. Afterwards it reads busy=0, value 0x1234.
- Stale commit:
  - Stimulus: issue rd=7 with tag 2, then issue rd=7 with tag 6, then commit rd=7 with tag 2 and value 0xAA.
  - Required: value 0xAA, busy=1, tag=6. Then commit rd=7 with tag 6 and value 0xBB gives value 0xBB, busy=0.
- Same-cycle issue and commit:
  - Stimulus: rd=9 is busy with tag 1; in one cycle, commit tag 1 value 0x55 and issue rd=9 tag 4.
  - Required: value 0x55, busy=1, tag=4.
- Flush and rdy_in:
  - Stimulus: rd=3,4 are busy; in one cycle, flush + commit rd=3 value 0x77 + issue rd=10.
  - Required: regs 3, 4 and 10 all read busy=0, and reg 3 reads 0x77.
  - Stimulus: repeat any write with `rdy_in`=0.
  - Required: no state change.
- Bypass:
  - Stimulus: `REGFILE_COMMIT_BYPASS_EN` defined; rd=12 busy with tag 5; commit rd=12 tag 5 value 0x99 while rs2_id=12.
  - Required: same cycle rs2_value=0x99, rs2_busy=0.
  - Stimulus: the same without the macro.
  - Required: same cycle reads old value, busy=1.
